rc4_prga: RTL and testbench

RC4 pseudo-random generation and decrypt engine. It is the consumer of the S-box that the key-scheduling stage leaves in `s_memory`. After that stage hands off, this block reads and swaps S entries, generates one keystream byte per message byte and XORs it with the encrypted-message ROM. Each plaintext byte is written to the decrypted-message RAM. It sits between the KSA controller and the decrypted-RAM/HEX readout logic in the top level.

---
 rtl/rc4_prga.sv | 202 ++++++++++++++++++++
 tb/tb_rc4_prga.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_prga.sv
// rc4_prga -- RC4 pseudo-random generation and decrypt engine.
//
// Takes over the S-box that the key-scheduling stage leaves in S memory.
// For each message byte it advances i, reads S[i], advances j, reads S[j],
// swaps the two entries with two sequential writes, reads
// S[S[i]+S[j]] together with the matching encrypted-ROM byte, and writes
// their XOR to the decrypted-message RAM. Each byte takes 12 cycles.
//
// Ports:
//   CLOCK_50     in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   start        in   level; accepted in IDLE and DONE
//   busy         out  high for every cycle of a run
//   done         out  high while in DONE
//   s_address    out  S-memory address
//   s_data       out  S-memory write data
//   s_wren       out  S-memory write enable
//   s_q          in   S-memory read data (valid two cycles after address)
//   rom_address  out  encrypted-ROM address
//   rom_q        in   encrypted-ROM read data (valid two cycles after address)
//   out_address  out  decrypted-RAM address
//   out_data     out  decrypted-RAM write data
//   out_wren     out  decrypted-RAM write enable
module rc4_prga #(
  parameter int MSG_LEN = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [7:0]        s_address,
  output logic [7:0]        s_data,
  output logic              s_wren,
  input  logic [7:0]        s_q,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [7:0]        rom_q,
  output logic [ADDR_W-1:0] out_address,
  output logic [7:0]        out_data,
  output logic              out_wren
);

  localparam logic [ADDR_W:0] K_LAST = (ADDR_W+1)'(MSG_LEN - 1);
  localparam logic [ADDR_W:0] K_ONE  = (ADDR_W+1)'(1);

  typedef enum logic [3:0] {
    IDLE,
    RD_I,
    WT_I,
    LD_I,
    RD_J,
    WT_J,
    LD_J,
    WR_I,
    WR_J,
    RD_F,
    WT_F,
    LD_F,
    WR_OUT,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        i_q, i_d;
  logic [7:0]        j_q, j_d;
  logic [ADDR_W:0]   k_q, k_d;
  logic [7:0]        si_q, si_d;
  logic [7:0]        sj_q, sj_d;
  logic [7:0]        f_q, f_d;
  logic [7:0]        enc_q, enc_d;

  // Control registers: state and the i/j/k indices.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  // Data capture registers; never observed outside the states that load them.
  always_ff @(posedge CLOCK_50) begin
    si_q  <= si_d;
    sj_q  <= sj_d;
    f_q   <= f_d;
    enc_q <= enc_d;
  end

  // Next-state and register updates.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    si_d    = si_q;
    sj_d    = sj_q;
    f_d     = f_q;
    enc_d   = enc_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          i_d     = 8'd0;
          j_d     = 8'd0;
          k_d     = '0;
          state_d = RD_I;
        end
      end
      RD_I: begin
        i_d     = i_q + 8'd1;
        state_d = WT_I;
      end
      WT_I: state_d = LD_I;
      LD_I: begin
        si_d    = s_q;
        j_d     = j_q + s_q;
        state_d = RD_J;
      end
      RD_J: state_d = WT_J;
      WT_J: state_d = LD_J;
      LD_J: begin
        sj_d    = s_q;
        state_d = WR_I;
      end
      WR_I: state_d = WR_J;
      WR_J: state_d = RD_F;
      RD_F: state_d = WT_F;
      WT_F: state_d = LD_F;
      LD_F: begin
        f_d     = s_q;
        enc_d   = rom_q;
        state_d = WR_OUT;
      end
      WR_OUT: begin
        k_d     = k_q + K_ONE;
        state_d = (k_q == K_LAST) ? DONE : RD_I;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode. Read addresses are held through the wait state so the
  // memory sees a stable address for both cycles of the read.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    s_address   = 8'd0;
    s_data      = 8'd0;
    s_wren      = 1'b0;
    rom_address = '0;
    out_address = '0;
    out_data    = 8'd0;
    out_wren    = 1'b0;
    unique case (state_q)
      IDLE: ;
      DONE: done = 1'b1;
      RD_I: begin
        busy      = 1'b1;
        s_address = i_q + 8'd1;
      end
      WT_I: begin
        busy      = 1'b1;
        s_address = i_q;
      end
      RD_J, WT_J: begin
        busy      = 1'b1;
        s_address = j_q;
      end
      WR_I: begin
        busy      = 1'b1;
        s_address = i_q;
        s_data    = sj_q;
        s_wren    = 1'b1;
      end
      WR_J: begin
        busy      = 1'b1;
        s_address = j_q;
        s_data    = si_q;
        s_wren    = 1'b1;
      end
      RD_F, WT_F: begin
        busy        = 1'b1;
        s_address   = si_q + sj_q;
        rom_address = k_q[ADDR_W-1:0];
      end
      WR_OUT: begin
        busy        = 1'b1;
        out_address = k_q[ADDR_W-1:0];
        out_data    = f_q ^ enc_q;
        out_wren    = 1'b1;
      end
      default: busy = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_rc4_prga.sv
`timescale 1ns/1ps
module tb_rc4_prga;
  localparam int AW = 5;
  localparam int LA = 9;
  localparam int LB = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, start_a, start_b, ld_a, ld_b, sel;

  logic            busy_a, done_a, s_wren_a, out_wren_a;
  logic [7:0]      s_address_a, s_data_a, s_q_a, rom_q_a, out_data_a;
  logic [AW-1:0]   rom_address_a, out_address_a;
  logic            busy_b, done_b, s_wren_b, out_wren_b;
  logic [7:0]      s_address_b, s_data_b, s_q_b, rom_q_b, out_data_b;
  logic [AW-1:0]   rom_address_b, out_address_b;

  rc4_prga #(.MSG_LEN(LA), .ADDR_W(AW)) dut_a (
    .CLOCK_50(clk), .reset_n(reset_n), .start(start_a), .busy(busy_a), .done(done_a),
    .s_address(s_address_a), .s_data(s_data_a), .s_wren(s_wren_a), .s_q(s_q_a),
    .rom_address(rom_address_a), .rom_q(rom_q_a),
    .out_address(out_address_a), .out_data(out_data_a), .out_wren(out_wren_a));

  rc4_prga #(.MSG_LEN(LB), .ADDR_W(AW)) dut_b (
    .CLOCK_50(clk), .reset_n(reset_n), .start(start_b), .busy(busy_b), .done(done_b),
    .s_address(s_address_b), .s_data(s_data_b), .s_wren(s_wren_b), .s_q(s_q_b),
    .rom_address(rom_address_b), .rom_q(rom_q_b),
    .out_address(out_address_b), .out_data(out_data_b), .out_wren(out_wren_b));

  // Memory images to load, and the two memory models (address registered,
  // data registered: read data appears two cycles after the address).
  logic [7:0] s_init [256];
  logic [7:0] r_init [32];
  logic [7:0] smem_a [256];
  logic [7:0] rmem_a [32];
  logic [7:0] smem_b [256];
  logic [7:0] rmem_b [32];
  logic [7:0] sadr_a, sadr_b;
  logic [AW-1:0] radr_a, radr_b;

  always @(posedge clk) begin
    sadr_a  <= s_address_a;
    radr_a  <= rom_address_a;
    s_q_a   <= smem_a[sadr_a];
    rom_q_a <= rmem_a[radr_a];
    if (ld_a) begin
      for (int x = 0; x < 256; x++) smem_a[x] <= s_init[x];
      for (int x = 0; x < 32; x++) rmem_a[x] <= r_init[x];
    end else if (s_wren_a) smem_a[s_address_a] <= s_data_a;
  end

  always @(posedge clk) begin
    sadr_b  <= s_address_b;
    radr_b  <= rom_address_b;
    s_q_b   <= smem_b[sadr_b];
    rom_q_b <= rmem_b[radr_b];
    if (ld_b) begin
      for (int y = 0; y < 256; y++) smem_b[y] <= s_init[y];
      for (int y = 0; y < 32; y++) rmem_b[y] <= r_init[y];
    end else if (s_wren_b) smem_b[s_address_b] <= s_data_b;
  end

  // Selected-DUT view for the shared monitor.
  logic          m_busy, m_done, m_sw, m_ow;
  logic [7:0]    m_sa, m_sd, m_od;
  logic [AW-1:0] m_ra, m_oa;
  always_comb begin
    if (sel) begin
      m_busy = busy_b; m_done = done_b; m_sw = s_wren_b; m_ow = out_wren_b;
      m_sa = s_address_b; m_sd = s_data_b; m_od = out_data_b;
      m_ra = rom_address_b; m_oa = out_address_b;
    end else begin
      m_busy = busy_a; m_done = done_a; m_sw = s_wren_a; m_ow = out_wren_a;
      m_sa = s_address_a; m_sd = s_data_a; m_od = out_data_a;
      m_ra = rom_address_a; m_oa = out_address_a;
    end
  end

  function automatic logic [7:0] s_rd(input int x);
    return sel ? smem_b[x] : smem_a[x];
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  // Reference model: plain RC4 PRGA over an array, i and j starting at 0.
  logic [7:0] m_s [256];
  logic [7:0] m_out [32];
  logic [7:0] exp_o [64];

  task automatic model_run(input int n);
    int i, j, t;
    i = 0; j = 0;
    for (int k = 0; k < n; k++) begin
      i = (i + 1) % 256;
      j = (j + int'(m_s[i])) % 256;
      t = int'(m_s[i]); m_s[i] = m_s[j]; m_s[j] = 8'(t);
      m_out[k] = m_s[(int'(m_s[i]) + int'(m_s[j])) % 256] ^ r_init[k];
    end
  endtask

  task automatic prep(input int L, input int nruns);
    for (int x = 0; x < 256; x++) m_s[x] = s_init[x];
    for (int r = 0; r < nruns; r++) begin
      model_run(L);
      for (int n = 0; n < L; n++) exp_o[r*L + n] = m_out[n];
    end
  endtask

  function automatic int s_diff();
    int d = 0;
    for (int x = 0; x < 256; x++) if (s_rd(x) !== m_s[x]) d++;
    return d;
  endfunction

  task automatic set_start(input logic v);
    if (sel) start_b = v; else start_a = v;
  endtask

  task automatic load_mem();
    @(negedge clk);
    if (sel) ld_b = 1'b1; else ld_a = 1'b1;
    @(negedge clk);
    ld_a = 1'b0; ld_b = 1'b0;
  endtask

  task automatic kick(input logic hold);
    @(negedge clk);
    set_start(1'b1);
    @(posedge clk);
    #1;
    if (!hold) set_start(1'b0);
  endtask

  // Monitor: cycle c is the c-th cycle after the edge that accepted start.
  int cap_cyc[$];
  int cap_adr[$];
  logic [7:0] cap_dat[$];
  int sw_cnt, done_cyc, done_n;
  logic bz [1024];
  logic dn [1024];
  logic [7:0] snap [3];

  task automatic capture(input int ncyc, input int stop_min, input int rel_cyc);
    cap_cyc.delete(); cap_adr.delete(); cap_dat.delete();
    sw_cnt = 0; done_cyc = 0; done_n = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (c == rel_cyc) set_start(1'b0);
      bz[c] = m_busy;
      dn[c] = m_done;
      if (m_ow) begin
        cap_cyc.push_back(c);
        cap_adr.push_back(int'(m_oa));
        cap_dat.push_back(m_od);
      end
      if (m_sw) sw_cnt++;
      if (c == 37) begin
        snap[0] = s_rd(2); snap[1] = s_rd(3); snap[2] = s_rd(5);
      end
      if (m_done) begin
        done_n++;
        if (done_cyc == 0) done_cyc = c;
        if (c >= stop_min) break;
      end
    end
  endtask

  function automatic int ctl_bad(input int first, input int last);
    int b = 0;
    for (int c = first; c <= last; c++) if (!bz[c] || dn[c]) b++;
    return b;
  endfunction

  task automatic chk_events(input int L, input int nruns);
    chk("n_out_writes", cap_cyc.size(), L * nruns);
    for (int e = 0; e < cap_cyc.size() && e < L * nruns; e++) begin
      int r, n;
      r = e / L;
      n = e % L;
      chk($sformatf("wr%0d_cycle", e), cap_cyc[e], r * (12*L + 1) + 12 * (n + 1));
      chk($sformatf("wr%0d_addr", e), cap_adr[e], n);
      chk($sformatf("wr%0d_data", e), cap_dat[e], exp_o[e]);
    end
  endtask

  task automatic full_run(input int L, input string tag);
    load_mem();
    kick(1'b0);
    capture(12*L + 20, 1, 0);
    chk_events(L, 1);
    chk({tag, "_done_cycle"}, done_cyc, 12*L + 1);
    chk({tag, "_s_wren_cycles"}, sw_cnt, 2*L);
    chk({tag, "_busy_in_run"}, ctl_bad(1, 12*L), 0);
    chk({tag, "_busy_after"}, bz[12*L + 1], 0);
    chk({tag, "_s_final"}, s_diff(), 0);
  endtask

  task automatic rand_images();
    logic [7:0] t;
    int y;
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    for (int x = 255; x > 0; x--) begin
      y = int'($urandom_range(x, 0));
      t = s_init[x]; s_init[x] = s_init[y]; s_init[y] = t;
    end
    for (int x = 0; x < 32; x++) r_init[x] = 8'($urandom);
  endtask

  typedef struct {
    int         skind;   // 0 identity S, 1 KSA("Key")
    logic [71:0] rom;    // ROM[0] in the top byte
    int         nchk;
    logic [71:0] expv;   // required out[0..] in the top bytes
  } vec_t;
  vec_t tbl [3];

  initial begin
    logic [7:0] key [3];
    int j, t, cnt;

    tbl[0] = '{0, 72'h0, 3, 72'h020507_000000000000};
    tbl[1] = '{0, 72'hFF0000_000000000000, 3, 72'hFD0507_000000000000};
    tbl[2] = '{1, 72'hBBF316E8D940AF0AD3, 9, 72'h506C61696E74657874};
    key[0] = 8'h4B; key[1] = 8'h65; key[2] = 8'h79;

    reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    ld_a = 1'b0; ld_b = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk($sformatf("reset_ctl_%0d", s), {m_busy, m_done, m_sw, m_ow}, 0);
      chk($sformatf("reset_bus_%0d", s), {m_sa, m_sd, m_ra, m_oa, m_od}, 0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    sel = 1'b0;

    // Directed vectors on the 9-byte instance.
    for (int v = 0; v < 3; v++) begin
      for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
      if (tbl[v].skind == 1) begin
        j = 0;
        for (int x = 0; x < 256; x++) begin
          j = (j + int'(s_init[x]) + int'(key[x % 3])) % 256;
          t = int'(s_init[x]); s_init[x] = s_init[j]; s_init[j] = 8'(t);
        end
      end
      for (int x = 0; x < 32; x++) r_init[x] = (x < 9) ? tbl[v].rom[71 - 8*x -: 8] : 8'h00;
      prep(LA, 1);
      full_run(LA, $sformatf("vec%0d", v));
      for (int n = 0; n < tbl[v].nchk && n < cap_dat.size(); n++)
        chk($sformatf("vec%0d_out%0d", v, n), cap_dat[n], tbl[v].expv[71 - 8*n -: 8]);
      if (v == 0) begin
        chk("ident_S2", snap[0], 8'h03);
        chk("ident_S3", snap[1], 8'h05);
        chk("ident_S5", snap[2], 8'h02);
      end
    end

    // Random S permutations and ROM on the 32-byte instance.
    sel = 1'b1;
    for (int r = 0; r < 2; r++) begin
      rand_images();
      prep(LB, 1);
      full_run(LB, $sformatf("rand%0d", r));
    end

    // Reset in cycle 50 of a run, then a clean rerun from reloaded S.
    rand_images();
    load_mem();
    kick(1'b0);
    capture(50, 9999, 0);
    chk("busy_before_reset", bz[50], 1);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_ctl", {m_busy, m_done, m_sw, m_ow}, 0);
    chk("midreset_bus", {m_sa, m_sd, m_ra, m_oa, m_od}, 0);
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 2) reset_n = 1'b1;
      if (m_sw || m_ow || m_busy || m_done) cnt++;
    end
    chk("no_activity_after_reset", cnt, 0);
    prep(LB, 1);
    full_run(LB, "after_reset");

    // start held into DONE: immediate restart on the already-permuted S.
    rand_images();
    prep(LB, 2);
    load_mem();
    kick(1'b1);
    capture(800, 12*LB + 2, 12*LB + 16);
    chk_events(LB, 2);
    chk("hold_first_done", done_cyc, 12*LB + 1);
    chk("hold_done_cycles", done_n, 2);
    chk("hold_s_wren_cycles", sw_cnt, 4*LB);
    chk("hold_busy_run1", ctl_bad(1, 12*LB), 0);
    chk("hold_busy_run2", ctl_bad(12*LB + 2, 24*LB + 1), 0);
    chk("hold_s_final", s_diff(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
